// File: rtl/best_arr_sender.sv
// Streams the best-match index array from the best-array RAM into the output FIFO.
// The order is two column halves, then BLOCKING-wide column blocks, then rows, then columns within a block.
module best_arr_sender #(
  parameter int DATA_WIDTH = 11,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_best_arr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_fifo_wenq,
  output logic [DATA_WIDTH-1:0] out_fifo_wdata,
  input  logic                  out_fifo_wfull_n
);

  localparam int HALF = ROW_SIZE / 2;
  localparam int NBLK = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int XW   = $clog2(NBLK + 1);
  localparam int YW   = $clog2(COL_SIZE + 1);
  localparam int IW   = $clog2(BLOCKING + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [ADDR_WIDTH-1:0] tuple_addr(input logic          px,
                                                       input logic [XW-1:0] x,
                                                       input logic [YW-1:0] y,
                                                       input logic [IW-1:0] xi);
    logic [31:0] a;
    a = 32'(px) * 32'(HALF) + 32'(y) * 32'(ROW_SIZE) + 32'(x) * 32'(BLOCKING) + 32'(xi);
    return a[ADDR_WIDTH-1:0];
  endfunction

  state_t                 state_q;
  logic                   px_q;
  logic [XW-1:0]          x_q;
  logic [YW-1:0]          y_q;
  logic [IW-1:0]          xi_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   rd_vld_q;
  logic [1:0]             cnt_q;
  logic [DATA_WIDTH-1:0]  head_q;
  logic [DATA_WIDTH-1:0]  tail_q;

  logic                   px_d;
  logic [XW-1:0]          x_d;
  logic [YW-1:0]          y_d;
  logic [IW-1:0]          xi_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic                   row_end;
  logic                   last_tuple;
  logic                   pop;
  logic                   issue;
  logic [2:0]             occ;

  // Occupancy counts skid entries plus the read whose data is on the bus, net of this cycle's pop.
  assign pop   = (cnt_q != 2'd0) && out_fifo_wfull_n;
  assign occ   = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
  assign issue = (state_q == RUN) && (occ < 3'd2);

  always_comb begin
    row_end    = (32'(xi_q) == 32'(BLOCKING - 1)) ||
                 (32'(x_q) * 32'(BLOCKING) + 32'(xi_q) + 32'd1 >= 32'(HALF));
    last_tuple = px_q && (32'(x_q) == 32'(NBLK - 1)) &&
                 (32'(y_q) == 32'(COL_SIZE - 1)) && row_end;
    px_d = px_q;
    x_d  = x_q;
    y_d  = y_q;
    xi_d = xi_q + 1'b1;
    // Columns past HALF in the last block are skipped by wrapping xi early.
    if (row_end) begin
      xi_d = '0;
      y_d  = y_q + 1'b1;
      if (32'(y_q) == 32'(COL_SIZE - 1)) begin
        y_d = '0;
        x_d = x_q + 1'b1;
        if (32'(x_q) == 32'(NBLK - 1)) begin
          x_d  = '0;
          px_d = ~px_q;
        end
      end
    end
    addr_d = tuple_addr(px_d, x_d, y_d, xi_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      px_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xi_q     <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      cnt_q    <= 2'd0;
      head_q   <= '0;
    end else begin
      rd_vld_q <= issue;
      done_q   <= 1'b0;
      if (issue) begin
        px_q   <= px_d;
        x_q    <= x_d;
        y_q    <= y_d;
        xi_q   <= xi_d;
        addr_q <= addr_d;
      end
      case ({rd_vld_q, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= mem_rd_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: head_q <= (cnt_q == 2'd1) ? mem_rd_data : tail_q;
        default: ;
      endcase
      case (state_q)
        IDLE: if (send_best_arr) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: if (issue && last_tuple) state_q <= DRAIN;
        DRAIN: if (occ == 3'd0) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Second skid slot: only written when the head is occupied and stays occupied.
  always_ff @(posedge clk) begin
    if (rd_vld_q && (((cnt_q == 2'd1) && !pop) || ((cnt_q == 2'd2) && pop)))
      tail_q <= mem_rd_data;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_rd_en      = issue;
  assign mem_rd_addr    = addr_q;
  assign out_fifo_wenq  = (cnt_q != 2'd0);
  assign out_fifo_wdata = head_q;

endmodule

// File: tb/tb_best_arr_sender.sv
// Bench for best_arr_sender: randomized FIFO backpressure against an order/occupancy model,
// plus a small-geometry instance for the ROW_SIZE=8 variant.
module tb_best_arr_sender;

  localparam int NW = 494;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, rd_en, wenq, wfull_n;
  logic [8:0]  rd_addr;
  logic [10:0] rd_data, wdata;

  logic        s_start;
  logic        s_busy, s_done, s_rd_en, s_wenq, s_wfull_n;
  logic [3:0]  s_rd_addr;
  logic [10:0] s_rd_data, s_wdata;

  always #5 clk = ~clk;

  best_arr_sender u_dut (
    .clk(clk), .rst(rst), .send_best_arr(start), .busy(busy), .done(done),
    .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
    .out_fifo_wenq(wenq), .out_fifo_wdata(wdata), .out_fifo_wfull_n(wfull_n)
  );

  best_arr_sender #(.ROW_SIZE(8), .COL_SIZE(2), .BLOCKING(4)) u_small (
    .clk(clk), .rst(rst), .send_best_arr(s_start), .busy(s_busy), .done(s_done),
    .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr), .mem_rd_data(s_rd_data),
    .out_fifo_wenq(s_wenq), .out_fifo_wdata(s_wdata), .out_fifo_wfull_n(s_wfull_n)
  );

  // Memories hold mem[a] = a; the bus carries junk whenever no read was issued.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 11'(rd_addr);
    else       rd_data <= 11'($urandom);
    if (s_rd_en) s_rd_data <= 11'(s_rd_addr);
    else         s_rd_data <= 11'($urandom);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  int ord_q[$];
  function automatic void load_order(input int rs, input int cs, input int blk);
    int half, nblk;
    half = rs / 2;
    nblk = (half + blk - 1) / blk;
    ord_q.delete();
    for (int px = 0; px < 2; px++)
      for (int x = 0; x < nblk; x++)
        for (int y = 0; y < cs; y++)
          for (int xi = 0; xi < blk; xi++)
            if (x * blk + xi < half) ord_q.push_back(px * half + y * rs + x * blk + xi);
  endfunction

  int bp_mode = 0;
  initial begin
    wfull_n   = 1'b1;
    s_wfull_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       begin wfull_n = 1'($urandom_range(0, 1)); s_wfull_n = 1'($urandom_range(0, 1)); end
        2:       begin wfull_n = 1'b0; s_wfull_n = 1'b0; end
        default: begin wfull_n = 1'b1; s_wfull_n = 1'b1; end
      endcase
    end
  end

  // Behavioural model and compare process for the default instance.
  int   phase = 0;
  logic armed = 1'b0, after_rst = 1'b0, prev_hold = 1'b0;
  logic exp_busy = 1'b0, exp_done = 1'b0;
  logic [10:0] prev_wdata = '0;
  int   exp_q[$], addr_q[$];
  int   n_acc = 0, n_iss = 0, done_cnt = 0, done_rel = 0, start_cyc = 0;
  int   acc_rel[NW], acc_dat[NW];
  logic acc_now;

  always @(negedge clk) begin
    acc_now = wenq && wfull_n;
    if (armed) begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
      if (after_rst) begin
        chk("post_rst_wenq", int'(wenq), 0);
        chk("post_rst_rd_en", int'(rd_en), 0);
        chk("post_rst_rd_addr", int'(rd_addr), 0);
        chk("post_rst_wdata", int'(wdata), 0);
      end
      if (prev_hold) begin
        chk("hold_wenq", int'(wenq), 1);
        chk("hold_wdata", int'(wdata), int'(prev_wdata));
      end
      if (rd_en) begin
        chk("rd_expected", int'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) chk("rd_addr", int'(rd_addr), addr_q.pop_front());
        n_iss++;
      end
      if (acc_now) begin
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (n_acc < NW) begin
          acc_rel[n_acc] = cyc - start_cyc;
          acc_dat[n_acc] = int'(wdata);
        end
        if (exp_q.size() > 0) chk("wdata_order", int'(wdata), exp_q.pop_front());
        n_acc++;
      end
      if (phase == 1) chk("outstanding_le_2", int'(n_iss - n_acc <= 2), 1);
      if (done) begin
        done_cnt++;
        done_rel = cyc - start_cyc;
      end
    end
    prev_hold  = wenq && !wfull_n && !rst;
    prev_wdata = wdata;
    after_rst  = rst;
    if (rst) begin
      armed    = 1'b1;
      phase    = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_q.delete();
      addr_q.delete();
    end else begin
      exp_done = 1'b0;
      case (phase)
        0: if (start) begin
          phase = 1;
          exp_busy = 1'b1;
          load_order(26, 19, 4);
          exp_q  = ord_q;
          addr_q = ord_q;
          n_iss = 0;
          n_acc = 0;
          done_cnt = 0;
          start_cyc = cyc;
        end
        1: if (acc_now && exp_q.size() == 0) begin
          phase = 2;
          exp_busy = 1'b0;
          exp_done = 1'b1;
        end
        default: phase = 0;
      endcase
    end
  end

  // Recorder for the small-geometry instance.
  int rx2[$];
  int done2_cnt = 0, done2_cyc = 0, last_acc2 = 0;
  always @(negedge clk) begin
    if (s_wenq && s_wfull_n) begin
      rx2.push_back(int'(s_wdata));
      last_acc2 = cyc;
    end
    if (s_done) begin
      done2_cnt++;
      done2_cyc = cyc;
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk({tag, "_done_seen"}, int'(done_cnt > 0), 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2[16] = '{0, 1, 2, 3, 8, 9, 10, 11, 4, 5, 6, 7, 12, 13, 14, 15};

    // Pin the order model with hand-derived values.
    load_order(26, 19, 4);
    chk("model_size", ord_q.size(), 494);
    chk("model_w4", ord_q[4], 26);
    chk("model_w76", ord_q[76], 4);
    chk("model_w229", ord_q[229], 38);
    chk("model_w247", ord_q[247], 13);
    load_order(8, 2, 4);
    chk("model_small_w8", ord_q[8], 4);

    rst = 1'b1; start = 1'b0; s_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_wenq", int'(wenq), 0);
    chk("reset_wdata", int'(wdata), 0);

    // Full sweep, no backpressure.
    bp_mode = 0;
    do_start();
    wait_done(700, "s1");
    chk("s1_count", n_acc, NW);
    chk("s1_first_wenq_cycle", acc_rel[0], 3);
    chk("s1_last_write_cycle", acc_rel[NW-1], 3 + NW - 1);
    chk("s1_done_cycle", done_rel, 3 + NW);
    chk("s1_done_pulses", done_cnt, 1);
    chk("s1_w0", acc_dat[0], 0);
    chk("s1_w1", acc_dat[1], 1);
    chk("s1_w2", acc_dat[2], 2);
    chk("s1_w3", acc_dat[3], 3);
    chk("s1_w4", acc_dat[4], 26);
    chk("s1_w76", acc_dat[76], 4);
    chk("s1_w228", acc_dat[228], 12);
    chk("s1_w229", acc_dat[229], 38);
    chk("s1_w247", acc_dat[247], 13);
    chk("s1_w493", acc_dat[493], 493);

    // Random backpressure.
    bp_mode = 1;
    do_start();
    wait_done(3000, "s2");
    chk("s2_count", n_acc, NW);
    chk("s2_done_pulses", done_cnt, 1);

    // Stall at start.
    bp_mode = 2;
    repeat (2) @(posedge clk);
    do_start();
    repeat (20) @(posedge clk);
    #1;
    chk("s3_reads_while_stalled", n_iss, 2);
    chk("s3_writes_while_stalled", n_acc, 0);
    bp_mode = 0;
    wait_done(700, "s3");
    chk("s3_back_to_back", acc_rel[1] - acc_rel[0], 1);
    chk("s3_w0", acc_dat[0], 0);
    chk("s3_w1", acc_dat[1], 1);
    chk("s3_count", n_acc, NW);

    // Reset mid-stream, then restart.
    bp_mode = 1;
    do_start();
    for (int i = 0; i < 2000 && n_acc < 100; i++) @(negedge clk);
    chk("s4_reached_100", int'(n_acc >= 100), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("s4_wenq_after_rst", int'(wenq), 0);
    chk("s4_busy_after_rst", int'(busy), 0);
    chk("s4_done_after_rst", int'(done), 0);
    repeat (3) @(posedge clk);
    do_start();
    wait_done(3000, "s4");
    chk("s4_count", n_acc, NW);

    // Spurious start while busy.
    bp_mode = 0;
    do_start();
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(700, "s5");
    repeat (10) @(posedge clk);
    #1;
    chk("s5_count", n_acc, NW);
    chk("s5_done_pulses", done_cnt, 1);

    // Small geometry variant under backpressure.
    bp_mode = 1;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int i = 0; i < 300 && done2_cnt == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("s6_count", rx2.size(), 16);
    for (int i = 0; i < 16; i++)
      chk("s6_word", (i < rx2.size()) ? rx2[i] : -1, exp2[i]);
    chk("s6_done_pulses", done2_cnt, 1);
    chk("s6_done_after_last", done2_cyc - last_acc2, 1);
    chk("s6_busy_end", int'(s_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
